// File: rtl/motor_ramp_pkg.sv
// Shared motor-command encodings and ramp FSM states, common to motor_ramp and pulseout.
package motor_ramp_pkg;

  localparam logic [1:0] FORWARD    = 2'b00;
  localparam logic [1:0] NEUTRAL    = 2'b01;
  localparam logic [1:0] REVERSE    = 2'b10;
  localparam logic [4:0] MC_NEUTRAL = 5'b00001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } ch_state_e;

  // The unused code 2'b11 is folded into NEUTRAL so nothing downstream ever sees it.
  function automatic logic [1:0] norm_dir(input logic [1:0] dir);
    return (dir == 2'b11) ? NEUTRAL : dir;
  endfunction

endpackage

// File: rtl/ramp_channel.sv
// One motor channel: latched target, IDLE/DRIVE/HOLD slew FSM and registered command.
module ramp_channel
  import motor_ramp_pkg::*;
#(
  parameter int unsigned NEUTRAL_HOLD_TICKS = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       load_i,
  input  logic       estop_i,
  input  logic [4:0] tgt_i,
  output logic [4:0] mc_o,
  output logic       settled_o
);

  localparam logic [3:0] HOLD_LOAD = 4'(NEUTRAL_HOLD_TICKS);

  logic [4:0] tgt_q, tgt_d;
  ch_state_e  state_q, state_d;
  logic [2:0] power_q, power_d;
  logic [1:0] dir_q, dir_d;
  logic [3:0] hold_q, hold_d;
  logic [4:0] mc_q, mc_d;

  logic [1:0] tgt_dir;
  logic [2:0] tgt_pow;

  assign tgt_dir = tgt_q[1:0];
  assign tgt_pow = tgt_q[4:2];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    tgt_d   = tgt_q;
    state_d = state_q;
    power_d = power_q;
    dir_d   = dir_q;
    hold_d  = hold_q;

    if (estop_i) begin
      tgt_d   = MC_NEUTRAL;
      state_d = HOLD;
      hold_d  = HOLD_LOAD;
    end else begin
      if (load_i) tgt_d = {tgt_i[4:2], norm_dir(tgt_i[1:0])};
      // The FSM reads tgt_q, so a command landing on a tick edge waits for the next tick.
      if (tick_i) begin
        case (state_q)
          IDLE: begin
            if (tgt_dir == FORWARD || tgt_dir == REVERSE) begin
              state_d = DRIVE;
              dir_d   = tgt_dir;
              power_d = 3'd0;
            end
          end
          DRIVE: begin
            if (tgt_dir == dir_q) begin
              if (power_q < tgt_pow)      power_d = power_q + 3'd1;
              else if (power_q > tgt_pow) power_d = power_q - 3'd1;
            end else if (power_q != 3'd0) begin
              power_d = power_q - 3'd1;
            end else begin
              state_d = HOLD;
              hold_d  = HOLD_LOAD;
            end
          end
          HOLD: begin
            if (hold_q == 4'd1) state_d = IDLE;
            else                hold_d  = hold_q - 4'd1;
          end
          default: state_d = IDLE;
        endcase
      end
    end

    mc_d = (state_d == DRIVE) ? {power_d, dir_d} : MC_NEUTRAL;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tgt_q   <= MC_NEUTRAL;
      state_q <= IDLE;
      power_q <= 3'd0;
      dir_q   <= NEUTRAL;
      hold_q  <= 4'd0;
      mc_q    <= MC_NEUTRAL;
    end else begin
      tgt_q   <= tgt_d;
      state_q <= state_d;
      power_q <= power_d;
      dir_q   <= dir_d;
      hold_q  <= hold_d;
      mc_q    <= mc_d;
    end
  end

  assign mc_o      = mc_q;
  assign settled_o = ((tgt_dir == NEUTRAL) && (state_q == IDLE)) ||
                     ((state_q == DRIVE) && (dir_q == tgt_dir) && (power_q == tgt_pow));

endmodule

// File: rtl/motor_ramp.sv
// Two-channel motor command slew limiter: shared ramp tick, command fan-out, settled AND.
module motor_ramp
  import motor_ramp_pkg::*;
#(
  parameter int unsigned STEP_CYCLES        = 1200000,
  parameter int unsigned NEUTRAL_HOLD_TICKS = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CMD_VALID,
  input  logic [4:0] TGT1,
  input  logic [4:0] TGT2,
  input  logic       ESTOP,
  output logic [4:0] MC1,
  output logic [4:0] MC2,
  output logic       TICK,
  output logic       SETTLED
);

  localparam int unsigned CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic          load;
  logic          settled1, settled2;

  // TICK is registered against the next count so it is high exactly while cnt_q == LAST.
  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    tick_d = (cnt_d == LAST);
  end

  // NOTE: only control/datapath flops exist here, so all of them take the async reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign load = CMD_VALID & ~ESTOP;

  ramp_channel #(.NEUTRAL_HOLD_TICKS(NEUTRAL_HOLD_TICKS)) u_ch1 (
    .clk_i     (CLK),
    .rst_i     (RST),
    .tick_i    (tick_q),
    .load_i    (load),
    .estop_i   (ESTOP),
    .tgt_i     (TGT1),
    .mc_o      (MC1),
    .settled_o (settled1)
  );

  ramp_channel #(.NEUTRAL_HOLD_TICKS(NEUTRAL_HOLD_TICKS)) u_ch2 (
    .clk_i     (CLK),
    .rst_i     (RST),
    .tick_i    (tick_q),
    .load_i    (load),
    .estop_i   (ESTOP),
    .tgt_i     (TGT2),
    .mc_o      (MC2),
    .settled_o (settled2)
  );

  assign TICK    = tick_q;
  assign SETTLED = settled1 & settled2;

endmodule

// File: tb/tb_motor_ramp.sv
// Directed bench for motor_ramp with STEP_CYCLES=10 and NEUTRAL_HOLD_TICKS=2.
module tb_motor_ramp;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CMD_VALID;
  logic [4:0] TGT1, TGT2;
  logic       ESTOP;
  wire  [4:0] MC1, MC2;
  wire        TICK, SETTLED;

  int n_pass  = 0;
  int n_total = 0;

  motor_ramp #(.STEP_CYCLES(10), .NEUTRAL_HOLD_TICKS(2)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CMD_VALID (CMD_VALID),
    .TGT1      (TGT1),
    .TGT2      (TGT2),
    .ESTOP     (ESTOP),
    .MC1       (MC1),
    .MC2       (MC2),
    .TICK      (TICK),
    .SETTLED   (SETTLED)
  );

  always #5 CLK = ~CLK;

  // Advance to the negedge just after the next tick edge (outputs then reflect that tick).
  task automatic step_tick;
    int k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (TICK !== 1'b1 && k < 40);
    if (TICK !== 1'b1) begin
      $display("FAIL tick_timeout got no TICK within %0d cycles, want one within 10", k);
      n_total++;
    end
    @(negedge CLK);
  endtask

  task automatic send_cmd(input logic [4:0] t1, input logic [4:0] t2);
    TGT1 = t1; TGT2 = t2; CMD_VALID = 1'b1;
    @(negedge CLK);
    CMD_VALID = 1'b0;
  endtask

  task automatic test_reset;
    int k;
    RST = 1'b1; CMD_VALID = 1'b0; ESTOP = 1'b0; TGT1 = 5'b00001; TGT2 = 5'b00001;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    n_total++;
    if (MC1 !== 5'b00001 || MC2 !== 5'b00001) $display("FAIL reset_mc got %b/%b want 00001/00001", MC1, MC2);
    else n_pass++;
    n_total++;
    if (SETTLED !== 1'b1 || TICK !== 1'b0) $display("FAIL reset_flags got settled=%b tick=%b want 1/0", SETTLED, TICK);
    else n_pass++;
    k = 0;
    do begin @(negedge CLK); k++; end while (TICK !== 1'b1 && k < 40);
    n_total++;
    if (k !== 9) $display("FAIL first_tick got %0d cycles want 9", k);
    else n_pass++;
    k = 0;
    do begin @(negedge CLK); k++; end while (TICK !== 1'b1 && k < 40);
    n_total++;
    if (k !== 10) $display("FAIL tick_period got %0d cycles want 10", k);
    else n_pass++;
    @(negedge CLK);
  endtask

  task automatic test_ramp_up;
    logic [4:0] exp_mc [4] = '{5'b00000, 5'b00100, 5'b01000, 5'b01100};
    send_cmd(5'b01100, 5'b00001);
    n_total++;
    if (SETTLED !== 1'b0) $display("FAIL ramp_up_settled_latch got %b want 0", SETTLED);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step_tick();
      n_total++;
      if (MC1 !== exp_mc[i] || MC2 !== 5'b00001)
        $display("FAIL ramp_up_mc tick%0d got %b/%b want %b/00001", i + 1, MC1, MC2, exp_mc[i]);
      else n_pass++;
      n_total++;
      if (SETTLED !== (i == 3)) $display("FAIL ramp_up_settled tick%0d got %b want %b", i + 1, SETTLED, i == 3);
      else n_pass++;
    end
  endtask

  task automatic test_reversal;
    logic [4:0] exp_mc [8] = '{5'b01000, 5'b00100, 5'b00000, 5'b00001,
                               5'b00001, 5'b00001, 5'b00010, 5'b00110};
    send_cmd(5'b00110, 5'b00001);
    for (int i = 0; i < 8; i++) begin
      step_tick();
      n_total++;
      if (MC1 !== exp_mc[i]) $display("FAIL reversal_mc tick%0d got %b want %b", i + 1, MC1, exp_mc[i]);
      else n_pass++;
    end
    n_total++;
    if (SETTLED !== 1'b1) $display("FAIL reversal_settled got %b want 1", SETTLED);
    else n_pass++;
  endtask

  task automatic test_estop;
    logic [4:0] exp_mc [6] = '{5'b00000, 5'b00100, 5'b01000, 5'b01100, 5'b10000, 5'b10100};
    send_cmd(5'b00110, 5'b11100);
    for (int i = 0; i < 6; i++) begin
      step_tick();
      n_total++;
      if (MC2 !== exp_mc[i]) $display("FAIL estop_ramp_mc2 tick%0d got %b want %b", i + 1, MC2, exp_mc[i]);
      else n_pass++;
    end
    ESTOP = 1'b1;
    @(negedge CLK);
    n_total++;
    if (MC1 !== 5'b00001 || MC2 !== 5'b00001) $display("FAIL estop_immediate got %b/%b want 00001/00001", MC1, MC2);
    else n_pass++;
    TGT1 = 5'b01100; TGT2 = 5'b11100; CMD_VALID = 1'b1;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    @(negedge CLK);
    ESTOP = 1'b0;
    n_total++;
    if (SETTLED !== 1'b0) $display("FAIL estop_release_settled got %b want 0", SETTLED);
    else n_pass++;
    step_tick();
    n_total++;
    if (SETTLED !== 1'b0) $display("FAIL estop_hold1_settled got %b want 0", SETTLED);
    else n_pass++;
    step_tick();
    n_total++;
    if (SETTLED !== 1'b1 || MC2 !== 5'b00001) $display("FAIL estop_hold2 got settled=%b mc2=%b want 1/00001", SETTLED, MC2);
    else n_pass++;
    step_tick();
    n_total++;
    if (MC1 !== 5'b00001 || MC2 !== 5'b00001) $display("FAIL estop_cmd_ignored got %b/%b want 00001/00001", MC1, MC2);
    else n_pass++;
  endtask

  task automatic test_cmd_on_tick;
    int k = 0;
    while (TICK !== 1'b1 && k < 40) begin @(negedge CLK); k++; end
    n_total++;
    if (TICK !== 1'b1) $display("FAIL cmd_on_tick_find got tick=%b want 1", TICK);
    else n_pass++;
    send_cmd(5'b01000, 5'b00001);
    n_total++;
    if (MC1 !== 5'b00001) $display("FAIL cmd_on_tick_same got %b want 00001", MC1);
    else n_pass++;
    step_tick();
    n_total++;
    if (MC1 !== 5'b00000) $display("FAIL cmd_on_tick_next got %b want 00000", MC1);
    else n_pass++;
    step_tick();
    step_tick();
    n_total++;
    if (MC1 !== 5'b01000 || SETTLED !== 1'b1) $display("FAIL cmd_on_tick_p2 got %b settled=%b want 01000/1", MC1, SETTLED);
    else n_pass++;
  endtask

  task automatic test_dir11;
    logic [4:0] exp_mc [5] = '{5'b00100, 5'b00000, 5'b00001, 5'b00001, 5'b00001};
    send_cmd(5'b10111, 5'b00001);
    for (int i = 0; i < 5; i++) begin
      step_tick();
      n_total++;
      if (MC1 !== exp_mc[i]) $display("FAIL dir11_mc tick%0d got %b want %b", i + 1, MC1, exp_mc[i]);
      else n_pass++;
      n_total++;
      if (SETTLED !== (i == 4)) $display("FAIL dir11_settled tick%0d got %b want %b", i + 1, SETTLED, i == 4);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    send_cmd(5'b11100, 5'b11000);
    step_tick();
    step_tick();
    n_total++;
    if (MC1 !== 5'b00100 || MC2 !== 5'b00100) $display("FAIL reset_mid_pre got %b/%b want 00100/00100", MC1, MC2);
    else n_pass++;
    #2 RST = 1'b1;
    #1;
    n_total++;
    if (MC1 !== 5'b00001 || MC2 !== 5'b00001 || SETTLED !== 1'b1)
      $display("FAIL reset_mid_async got %b/%b settled=%b want 00001/00001/1", MC1, MC2, SETTLED);
    else n_pass++;
    @(negedge CLK);
    RST = 1'b0;
    step_tick();
    n_total++;
    if (MC1 !== 5'b00001 || MC2 !== 5'b00001) $display("FAIL reset_mid_after got %b/%b want 00001/00001", MC1, MC2);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_reversal();
    test_estop();
    test_cmd_on_tick();
    test_dir11();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/motor_ramp.md
Name: motor_ramp

Overview:
- Command slew limiter placed directly upstream of the 2-channel motor-controller pulse generator (pulseout).
- Takes target drive commands from the navigation logic and ramps the MC1/MC2 5-bit codes ({power[2:0], dir[1:0]}) one power step per refresh tick.
- Forces a ramp-down and a neutral dwell before any direction change, to remove mechanical shakiness from abrupt reversals.

Parameters:
- STEP_CYCLES, 1200000: CLK cycles per ramp tick; 12 ms at 100 MHz, matches the pulse refresh period.
- NEUTRAL_HOLD_TICKS, 4: ticks spent in neutral between direction changes; legal range 1..15.

Ports:
- CLK  in  1  system clock, 100 MHz.
- RST  in  1  asynchronous, active-high reset.
- CMD_VALID  in  1  one-cycle strobe; latches TGT1 and TGT2 together.
- TGT1  in  5  left-motor target {power[2:0], dir[1:0]}.
- TGT2  in  5  right-motor target, same format.
- ESTOP  in  1  level; forces both channels to neutral immediately.
- MC1  out  5  left-motor command to the pulse generator, registered.
- MC2  out  5  right-motor command, registered.
- TICK  out  1  one-cycle ramp-tick pulse, registered.
- SETTLED  out  1  high when both channels equal their latched targets.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-high on RST.
- Dir encoding: 00 FORWARD, 01 NEUTRAL, 10 REVERSE. 11 is treated as NEUTRAL everywhere, both on input latch and on output.
- Neutral output code is 5'b00001. Power is 0..7. FORWARD or REVERSE at power 0 is minimum drive, not stop.
- Reset values:
  - MC1 = MC2 = 5'b00001; TICK = 0; tick counter = 0.
  - Latched targets = 5'b00001; both channels in IDLE; SETTLED = 1.
- Tick generator:
  - Counter runs 0..STEP_CYCLES-1, wraps to 0.
  - TICK = 1 for exactly the cycle when the counter equals STEP_CYCLES-1.
  - The counter free-runs and is not restarted by CMD_VALID.
- Target latch:
  - On CMD_VALID=1 with ESTOP=0, both targets register on that edge.
  - If CMD_VALID and TICK coincide, the tick acts on the old targets; the new targets take effect from the next tick.
- Per-channel FSM (states IDLE, DRIVE, HOLD); transitions happen only on cycles with TICK=1, except ESTOP:
  - IDLE: output neutral.
    - Target dir FWD or REV → DRIVE, with cur_dir = target dir and power = 0.
    - Otherwise remain in IDLE.
  - DRIVE: output {power, cur_dir}.
    - Target dir == cur_dir: power moves one step toward target power (+1 or -1, or unchanged if equal). No overflow or underflow is possible.
    - Target dir differs (NEUTRAL or opposite): if power > 0, power -1; if power == 0, go to HOLD and load hold_cnt = NEUTRAL_HOLD_TICKS.
  - HOLD: output neutral.
    - On a tick, if hold_cnt == 1 → IDLE; otherwise hold_cnt -1.
    - A new target arriving during HOLD does not shorten the dwell.
- Output timing: MC is updated on the same clock edge where TICK=1, so the new code is visible the cycle after TICK is high. Latency from a tick to an output change is 1 cycle.
- Worst-case transition (full FORWARD to full REVERSE): 7 ticks down, 1 tick to enter HOLD, NEUTRAL_HOLD_TICKS ticks of dwell, 1 tick to DRIVE p0, 7 ticks up.
- ESTOP=1 (any cycle, not tick-gated):
  - On the next edge: both latched targets ← neutral, both channels → HOLD with hold_cnt reloaded every cycle, MC1 = MC2 = neutral.
  - CMD_VALID is ignored while ESTOP is high.
  - After release, HOLD counts down on ticks as normal.
- SETTLED: combinational from registered state, per channel:
  - (target neutral AND state IDLE) OR (state DRIVE AND cur_dir == target dir AND power == target power).
  - The two channel results are ANDed.
- Reset asserted mid-ramp: every register is asynchronously returned to its reset value; no partial output is held.

Decomposition:
- Shared package holds:
  - Dir constants FORWARD = 2'b00, NEUTRAL = 2'b01, REVERSE = 2'b10.
  - MC_NEUTRAL = 5'b00001.
  - FSM state encodings IDLE, DRIVE, HOLD.
- The same constants are used by pulseout.
- One sub-module, ramp_channel: target register, FSM, power/hold counters, per-channel settled flag. It is instantiated twice.
- The top level holds the tick counter, the CMD_VALID/ESTOP fan-out and the SETTLED AND.

Test Plan (bench uses STEP_CYCLES=10, NEUTRAL_HOLD_TICKS=2):
1. Reset asserted then released → MC1 = MC2 = 5'b00001, SETTLED = 1, TICK pulses every 10 cycles.
2. CMD_VALID with TGT1 = {3'd3, 2'b00} → MC1 after ticks 1..4 = 00000, 00100, 01000, 01100. SETTLED low until tick 4, then high. MC2 stays 00001 throughout.
3. From MC1 = 01100, TGT1 = {3'd1, 2'b10} → ticks 1-3: 01000, 00100, 00000; tick 4: 00001 (HOLD); tick 5: 00001; tick 6: IDLE, still 00001; tick 7: 00010; tick 8: 00110, SETTLED = 1.
4. ESTOP pulsed for 3 cycles mid-ramp at MC2 = 10100 → MC2 = 00001 on the next edge. A CMD_VALID during ESTOP is ignored. MC2 stays 00001 and SETTLED = 1 after release plus 2 ticks.
5. CMD_VALID in the same cycle as TICK (TGT1 = {3'd2, 2'b00}, previously neutral) → MC1 unchanged at that tick; 00000 after the next tick.
6. TGT1 = {3'd5, 2'b11} while driving FORWARD p2 → treated as NEUTRAL: ramps 00100, 00000, then 00001 (HOLD), ending in IDLE with SETTLED = 1.
